i2c_master_byte: RTL

//   Single-master I2C initiator that drives the sda/scl pair of the i2c-slave DUT.
//   - Each command is one transaction: START, 7-bit address + R/W, one data byte, STOP.
//   - Pins are open-drain: an *_oe output of 1 pulls the line low; 0 releases it to the pull-up.
//   - Instantiated in the tb wrapper, with pins resolved onto dut_if.sda/scl. Synthesizable.

---
 rtl/i2c_master_byte.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_byte.sv
// i2c_master_byte
//   Single-master I2C initiator. One command = START, 7-bit address + R/W,
//   one data byte, STOP. Open-drain pins: *_oe=1 pulls the line low.
// Parameters
//   CLK_DIV  clk cycles per SCL quarter-period (>= 2)
//   STRETCH  1: wait for scl_i high before entering the SCL-high phase
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_addr, cmd_rw, cmd_wdata  command fields (latched at accept)
//   rsp_valid                    one-cycle done pulse
//   rsp_rdata, rsp_nack          result, held until the next accept
//   busy                         transaction in progress (START..STOP)
//   scl_oe, sda_oe               1 = pull the line low
//   scl_i, sda_i                 sampled bus lines
module i2c_master_byte #(
  parameter int CLK_DIV = 125,
  parameter int STRETCH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i
);

  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_WRITE, S_WACK,
    S_READ, S_MNACK, S_STOP, S_RESP
  } state_t;

  state_t         state_q;
  logic [QW-1:0]  qcnt_q;
  logic [1:0]     ph_q;
  logic [2:0]     bit_q;
  logic [7:0]     sh_q;
  logic [7:0]     rx_q;
  logic [6:0]     addr_q;
  logic           rw_q;
  logic [7:0]     wdata_q;
  logic           cmd_ready_q, busy_q, rsp_valid_q, rsp_nack_q;
  logic [7:0]     rsp_rdata_q;
  logic           scl_oe_q, sda_oe_q;

  logic in_bit, q_last, stretch_wait, q_end;

  // Bit-timed states share the P0..P3 phase machinery; STOP reuses it too.
  assign in_bit = (state_q == S_ADDR)  || (state_q == S_AACK) ||
                  (state_q == S_WRITE) || (state_q == S_WACK) ||
                  (state_q == S_READ)  || (state_q == S_MNACK) ||
                  (state_q == S_STOP);
  assign q_last = (qcnt_q == QLAST);
  // A slave holding SCL low freezes the counter at its last P1 count.
  assign stretch_wait = (STRETCH != 0) && in_bit && (ph_q == 2'd1) && !scl_i;
  assign q_end = (state_q != S_IDLE) && (state_q != S_RESP) && q_last && !stretch_wait;

  // SDA pull value applied one clk into P0, after SCL has already gone low.
  function automatic logic sda_pull(input state_t s, input logic [7:0] sh);
    logic p;
    p = 1'b0;
    if ((s == S_ADDR) || (s == S_WRITE)) p = ~sh[7];
    else if (s == S_STOP)                p = 1'b1;
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      ph_q        <= '0;
      bit_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_nack_q  <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;

      if ((state_q != S_IDLE) && (state_q != S_RESP)) begin
        if (q_end) begin
          qcnt_q <= '0;
          ph_q   <= ph_q + 2'd1;
        end else if (!q_last) begin
          qcnt_q <= qcnt_q + 1'b1;
        end
      end

      if (in_bit && (ph_q == 2'd0) && (qcnt_q == '0))
        sda_oe_q <= sda_pull(state_q, sh_q);

      case (state_q)
        S_IDLE: begin
          scl_oe_q <= 1'b0;
          sda_oe_q <= 1'b0;
          if (!cmd_ready_q) begin
            cmd_ready_q <= 1'b1;
          end else if (cmd_valid) begin
            addr_q      <= cmd_addr;
            rw_q        <= cmd_rw;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_nack_q  <= 1'b0;
            qcnt_q      <= '0;
            ph_q        <= '0;
            state_q     <= S_START;
          end
        end

        // Q0 idle-high, Q1..Q2 SDA low with SCL high, Q3 SCL low.
        S_START: begin
          if (q_end) begin
            case (ph_q)
              2'd0: sda_oe_q <= 1'b1;
              2'd2: scl_oe_q <= 1'b1;
              2'd3: begin
                sh_q    <= {addr_q, rw_q};
                bit_q   <= '0;
                state_q <= S_ADDR;
              end
              default: ;
            endcase
          end
        end

        S_RESP: begin
          rsp_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          if (q_end) begin
            case (ph_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd1: begin
                if (((state_q == S_AACK) || (state_q == S_WACK)) && sda_i)
                  rsp_nack_q <= 1'b1;
                if (state_q == S_READ)
                  rx_q <= {rx_q[6:0], sda_i};
              end
              2'd2: if (state_q == S_STOP) sda_oe_q <= 1'b0;
              default: begin
                if (state_q == S_STOP) begin
                  busy_q  <= 1'b0;
                  state_q <= S_RESP;
                end else begin
                  scl_oe_q <= 1'b1;
                  case (state_q)
                    S_ADDR, S_WRITE: begin
                      sh_q <= {sh_q[6:0], 1'b0};
                      if (bit_q == 3'd7) begin
                        bit_q   <= '0;
                        state_q <= (state_q == S_ADDR) ? S_AACK : S_WACK;
                      end else begin
                        bit_q <= bit_q + 3'd1;
                      end
                    end
                    S_AACK: begin
                      if (rsp_nack_q) begin
                        state_q <= S_STOP;
                      end else if (rw_q) begin
                        state_q <= S_READ;
                      end else begin
                        sh_q    <= wdata_q;
                        state_q <= S_WRITE;
                      end
                    end
                    S_READ: begin
                      if (bit_q == 3'd7) begin
                        bit_q   <= '0;
                        state_q <= S_MNACK;
                      end else begin
                        bit_q <= bit_q + 3'd1;
                      end
                    end
                    S_MNACK: begin
                      rsp_rdata_q <= rx_q;
                      state_q     <= S_STOP;
                    end
                    default: state_q <= S_STOP;
                  endcase
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_nack  = rsp_nack_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule
